// File: rtl/beat_wave_gen_pkg.sv
// Shared constants and the P-QRS-T shape lookup for the synthetic heartbeat generator.
package beat_pkg;

  localparam int          MIN_PERIOD = 16;
  localparam int          R_IDX      = 6;
  localparam logic [3:0]  BASELINE   = 4'd2;
  localparam logic [3:0]  LFSR_SEED  = 4'b1001;

  // One beat's shape, indexed by phase 0..15.
  function automatic logic [3:0] shape_at(input logic [3:0] idx);
    logic [3:0] val;
    case (idx)
      4'd0:    val = 4'd2;
      4'd1:    val = 4'd3;
      4'd2:    val = 4'd4;
      4'd3:    val = 4'd3;
      4'd4:    val = 4'd2;
      4'd5:    val = 4'd1;
      4'd6:    val = 4'd15;
      4'd7:    val = 4'd0;
      4'd8:    val = 4'd2;
      4'd9:    val = 4'd2;
      4'd10:   val = 4'd4;
      4'd11:   val = 4'd5;
      4'd12:   val = 4'd5;
      4'd13:   val = 4'd4;
      4'd14:   val = 4'd2;
      4'd15:   val = 4'd2;
      default: val = BASELINE;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/beat_wave_gen_if.sv
// Control inputs and sample-stream outputs of the heartbeat generator.
interface beat_wave_gen_if #(
  parameter int SAMPLE_W = 4,
  parameter int DIV_W    = 8,
  parameter int PERIOD_W = 8
);
  logic                en;
  logic [DIV_W-1:0]    div;
  logic [PERIOD_W-1:0] period;
  logic [SAMPLE_W-1:0] sample;
  logic                sample_vld;
  logic                beat;
  logic [7:0]          beat_cnt;

  modport master (output en, div, period, input sample, sample_vld, beat, beat_cnt);
  modport slave  (input en, div, period, output sample, sample_vld, beat, beat_cnt);
endinterface

// File: rtl/beat_wave_gen_lfsr.sv
// 4-bit Fibonacci LFSR (x^4+x^3+1) stepping only when adv is high.
module beat_lfsr4
  import beat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [3:0] q
);

  // LFSR state register, seeded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (adv) begin
      q <= {q[2:0], q[3] ^ q[2]};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/beat_wave_gen.sv
// Synthetic ECG sample generator. Define BEAT_JITTER_EN to add 0..3 pseudo-random
// baseline samples to each beat.
module beat_wave_gen
  import beat_pkg::*;
#(
  parameter int SAMPLE_W = 4,
  parameter int DIV_W    = 8,
  parameter int PERIOD_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  beat_wave_gen_if.slave bus
);

  // One extra bit so a jittered period of up to 255+3 still fits.
  localparam int PH_W = PERIOD_W + 1;

  logic [DIV_W-1:0]    presc_r;
  logic [PH_W-1:0]     phase_r;
  logic [PH_W-1:0]     period_q_r;
  logic [PH_W-1:0]     base_period_s;
  logic [PH_W-1:0]     period_next_s;
  logic [SAMPLE_W-1:0] shape_s;
  logic                tick_s;
  logic                wrap_s;
  logic                r_peak_s;
  logic [SAMPLE_W-1:0] sample_r;
  logic                sample_vld_r;
  logic                beat_r;
  logic [7:0]          beat_cnt_r;

`ifdef BEAT_JITTER_EN
  logic [3:0] lfsr_q;

  beat_lfsr4 u_lfsr (
    .clk (clk),
    .rst (rst),
    .adv (tick_s & wrap_s),
    .q   (lfsr_q)
  );
`endif

  // Tick, wrap and next-beat length decode.
  always_comb begin
    tick_s        = 1'b0;
    wrap_s        = 1'b0;
    r_peak_s      = 1'b0;
    base_period_s = PH_W'(MIN_PERIOD);
    period_next_s = PH_W'(MIN_PERIOD);
    shape_s       = SAMPLE_W'(BASELINE);

    if (bus.en && (presc_r >= bus.div)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end

    if (phase_r == (period_q_r - PH_W'(1))) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end

    if (phase_r == PH_W'(R_IDX)) begin
      r_peak_s = 1'b1;
    end else begin
      r_peak_s = 1'b0;
    end

    if (bus.period < PERIOD_W'(MIN_PERIOD)) begin
      base_period_s = PH_W'(MIN_PERIOD);
    end else begin
      base_period_s = {1'b0, bus.period};
    end

`ifdef BEAT_JITTER_EN
    period_next_s = base_period_s + PH_W'(lfsr_q & 4'b0011);
`else
    period_next_s = base_period_s;
`endif

    // Phases past the shape table are flat baseline.
    if (phase_r < PH_W'(16)) begin
      shape_s = SAMPLE_W'(shape_at(phase_r[3:0]));
    end else begin
      shape_s = SAMPLE_W'(BASELINE);
    end
  end

  // Sample-rate prescaler; div is compared live every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else if (bus.en) begin
      presc_r <= presc_r + DIV_W'(1);
    end else begin
      presc_r <= presc_r;
    end
  end

  // Beat phase and latched beat length; a new period is only adopted at a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r    <= '0;
      period_q_r <= PH_W'(MIN_PERIOD);
    end else if (tick_s && wrap_s) begin
      phase_r    <= '0;
      period_q_r <= period_next_s;
    end else if (tick_s) begin
      phase_r    <= phase_r + PH_W'(1);
      period_q_r <= period_q_r;
    end else begin
      phase_r    <= phase_r;
      period_q_r <= period_q_r;
    end
  end

  // Registered sample stream, strobes and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_r     <= '0;
      sample_vld_r <= 1'b0;
      beat_r       <= 1'b0;
      beat_cnt_r   <= 8'd0;
    end else begin
      sample_vld_r <= tick_s;
      beat_r       <= tick_s & r_peak_s;
      if (tick_s) begin
        sample_r <= shape_s;
      end else begin
        sample_r <= sample_r;
      end
      if (tick_s && r_peak_s) begin
        beat_cnt_r <= beat_cnt_r + 8'd1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

  assign bus.sample     = sample_r;
  assign bus.sample_vld = sample_vld_r;
  assign bus.beat       = beat_r;
  assign bus.beat_cnt   = beat_cnt_r;

endmodule

// File: doc/beat_wave_gen.md
Name: beat_wave_gen

Overview:
Synthetic heartbeat (ECG-like) sample generator: the transmit-side counterpart that produces the 4-bit sample stream the threshold/peak detector consumes. It emits a fixed P-QRS-T shape at a programmable sample rate and beat period, with a strobe per sample and a marker on each R-peak. It is used as on-chip stimulus and for self-test of the detector path.

Parameters:
- SAMPLE_W, 4, sample width; the shape table is defined for 4 bits.
- DIV_W, 8, width of the sample-rate divider input.
- PERIOD_W, 8, width of the samples-per-beat input.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low freezes the generator.
- div  in  DIV_W  clock cycles per sample minus 1.
- period  in  PERIOD_W  samples per beat; values below 16 are treated as 16.
- sample  out  SAMPLE_W  current waveform sample (registered).
- sample_vld  out  1  one-cycle pulse when `sample` updates.
- beat  out  1  one-cycle pulse, coincident with sample_vld, on the R-peak sample.
- beat_cnt  out  8  count of beats emitted; wraps 255->0.

Behaviour:
- Reset (async, rst=1) values:
  - sample=0, sample_vld=0, beat=0, beat_cnt=0.
  - Prescaler=0, phase=0, period_q=16.
- Prescaler:
  - Counts while en=1.
  - tick is asserted when prescaler>=div; the prescaler then returns to 0, otherwise it increments.
  - div is used live. If div is lowered below the current count, tick fires on the next cycle.
- On a tick cycle, registered and effective the next cycle:
  - sample <= SHAPE[phase] if phase<16, else BASELINE (2).
  - sample_vld <= 1.
  - beat <= (phase==R_IDX).
  - beat_cnt increments with the same condition as beat.
  - phase <= phase+1, or 0 if phase==period_q-1.
- period_q:
  - Loaded from max(period,16) whenever phase wraps to 0.
  - A period change mid-beat takes effect at the next beat.
- On non-tick cycles: sample_vld=0, beat=0, and sample holds.
- SHAPE[0..15] = 2,3,4,3,2,1,15,0,2,2,4,5,5,4,2,2; R_IDX=6.
- Latency:
  - After rst deasserts with en=1, the first sample_vld occurs div+1 cycles later.
  - Samples repeat every div+1 cycles.
  - Beats repeat every period_q*(div+1) cycles.
- en=0:
  - Prescaler, phase and period_q hold; sample_vld=0 and beat=0.
  - On re-enable, the generator resumes from the held prescaler count and phase.
- Reset mid-beat: immediate return to the reset values; the next beat restarts at phase 0.

Optional Feature:
- Macro: BEAT_JITTER_EN.
- When defined:
  - A 4-bit LFSR (x^4+x^3+1, seed 4'b1001) advances once per phase wrap.
  - period_q = max(period,16) + lfsr[1:0], giving 0..3 extra baseline samples per beat.
- When undefined: no LFSR logic, and the period is exact.

Decomposition:
- Package beat_pkg:
  - SHAPE table and R_IDX=6.
  - MIN_PERIOD=16, BASELINE=2.
  - LFSR_SEED=4'b1001.
- Sub-module beat_lfsr4 (4-bit Fibonacci LFSR with advance enable and async rst); instantiated only under BEAT_JITTER_EN.

Test Plan:
- rst pulse mid-beat (phase 9) -> all outputs 0 asynchronously. After release with div=0, period=16: first sample_vld at cycle 1, with sample=2.
- div=0, period=16 -> sample_vld every cycle; sample sequence equals SHAPE; beat on the 7th sample (value 15); beat repeats every 16 cycles; beat_cnt increments by 1 per beat.
- div=3, period=20 -> sample_vld every 4 cycles; samples 17..20 of each beat =2; beat every 80 cycles. period=5 -> beats every 16 samples.
- en low for 10 cycles at phase 4 -> no sample_vld or beat during that window; on resume the next sample is SHAPE[4]=2, then 1, then 15 with beat.
- period changed 16->32 at phase 3 -> current beat still wraps after 16 samples; the next beat spans 32 samples. beat_cnt 255 -> 0 on the 256th beat.
- BEAT_JITTER_EN, div=0, period=16 -> beat-to-beat intervals equal 16+lfsr[1:0] following the seed-1001 sequence. Without the macro -> intervals are constant 16.
